mem_access_stage: RTL and testbench

//  Memory stage between the ALU/execute stage and register writeback. Takes one
//  ALU result per handshake (memOp + regOp fields of tAluOut). Drives a

---
 rtl/mem_access_stage_if.sv | 56 +++++
 rtl/mem_access_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Shared types and handshake/bus bundle for the memory-access stage.
package mem_access_pkg;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  opType;
    logic [4:0]  rdAddr;
  } tMemOp;

  typedef struct packed {
    logic        dv;
    logic [4:0]  addr;
    logic [31:0] data;
  } tRegOp;
endpackage

interface mem_access_stage_if;
  import mem_access_pkg::*;

  logic        in_valid;
  logic        in_ready;
  tMemOp       in_memOp;
  tRegOp       in_regOp;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_dv;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        bus_err;
  logic        misalign_err;

  modport master (
    output in_valid, in_memOp, in_regOp,
    output dmem_rdata, dmem_ack,
    input  in_ready, dmem_req, dmem_we,
    input  dmem_addr, dmem_wdata, dmem_be,
    input  wb_dv, wb_addr, wb_data,
    input  bus_err, misalign_err
  );

  modport slave (
    input  in_valid, in_memOp, in_regOp,
    input  dmem_rdata, dmem_ack,
    output in_ready, dmem_req, dmem_we,
    output dmem_addr, dmem_wdata, dmem_be,
    output wb_dv, wb_addr, wb_data,
    output bus_err, misalign_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage: single-outstanding data bus, store lanes, load extension.
// MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of issuing.
module mem_access_stage #(
  parameter int cDataWidth  = 32,
  parameter int cRegSelBitW = 5,
  parameter int cAckTimeout = 16
) (
  input logic               clk,
  input logic               rstN,
  mem_access_stage_if.slave bus
);
  localparam int CW =
    (cAckTimeout > 0) ? $clog2(cAckTimeout + 1) : 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   ld_q;
  logic [2:0]             op_q;
  logic [1:0]             lo_q;
  logic [cRegSelBitW-1:0] rd_q;

  logic        accept;
  logic        st;
  logic        mem;
  logic [31:0] a;
  logic [31:0] d;
  logic [2:0]  op;
  logic        byte_sz;
  logic        half_sz;
  logic        misal;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [7:0]  rb;
  logic [15:0] rh;
  logic [cDataWidth-1:0] ext;
  logic [CW-1:0] cnt_nx;
  logic        tmo;

  assign bus.in_ready = (state == IDLE);
  assign accept = bus.in_valid & bus.in_ready;
  assign a   = bus.in_memOp.addr;
  assign d   = bus.in_memOp.data;
  assign op  = bus.in_memOp.opType;
  assign st  = bus.in_memOp.write;
  assign mem = bus.in_memOp.read | st;

  // stores only know SB/SH; loads also have the unsigned forms
  always_comb begin
    byte_sz = 1'b0;
    half_sz = 1'b0;
    unique case (1'b1)
      (op[1:0] == 2'b00) && (!st || !op[2]):
        byte_sz = 1'b1;
      (op[1:0] == 2'b01) && (!st || !op[2]):
        half_sz = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    be = 4'b1111;
    wd = d;
    unique case (1'b1)
      byte_sz: begin
        be = 4'b0001 << a[1:0];
        wd = {4{d[7:0]}};
      end
      half_sz: begin
        be = a[1] ? 4'b1100 : 4'b0011;
        wd = {2{d[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = (half_sz & a[0])
               | (!byte_sz & !half_sz & (a[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign rb = 8'(bus.dmem_rdata >> {lo_q, 3'b000});
  assign rh = lo_q[1] ? bus.dmem_rdata[31:16]
                      : bus.dmem_rdata[15:0];

  always_comb begin
    ext = bus.dmem_rdata;
    unique case (op_q)
      3'b000: ext = {{24{rb[7]}}, rb};
      3'b100: ext = {24'd0, rb};
      3'b001: ext = {{16{rh[15]}}, rh};
      3'b101: ext = {16'd0, rh};
      default: ;
    endcase
  end

  assign cnt_nx = cnt + 1'b1;
  assign tmo = (cAckTimeout != 0)
             && (cnt_nx == CW'(cAckTimeout));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state            <= IDLE;
      cnt              <= '0;
      ld_q             <= 1'b0;
      op_q             <= '0;
      lo_q             <= '0;
      rd_q             <= '0;
      bus.dmem_req     <= 1'b0;
      bus.dmem_we      <= 1'b0;
      bus.dmem_addr    <= '0;
      bus.dmem_wdata   <= '0;
      bus.dmem_be      <= '0;
      bus.wb_dv        <= 1'b0;
      bus.wb_addr      <= '0;
      bus.wb_data      <= '0;
      bus.bus_err      <= 1'b0;
      bus.misalign_err <= 1'b0;
    end else begin
      bus.wb_dv        <= 1'b0;
      bus.bus_err      <= 1'b0;
      bus.misalign_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (!mem) begin
              bus.wb_dv <= bus.in_regOp.dv
                         & (bus.in_regOp.addr != '0);
              bus.wb_addr <= bus.in_regOp.addr;
              bus.wb_data <= bus.in_regOp.data;
            end else if (misal) begin
              bus.misalign_err <= 1'b1;
            end else begin
              state          <= ACCESS;
              cnt            <= '0;
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= st;
              bus.dmem_addr  <= {a[31:2], 2'b00};
              bus.dmem_be    <= be;
              bus.dmem_wdata <= wd;
              ld_q           <= !st;
              op_q           <= op;
              lo_q           <= a[1:0];
              rd_q           <= bus.in_memOp.rdAddr;
            end
          end
        end
        ACCESS: begin
          // an ack in the timeout cycle still completes the access
          if (bus.dmem_ack) begin
            state        <= IDLE;
            bus.dmem_req <= 1'b0;
            if (ld_q && (rd_q != '0)) begin
              bus.wb_dv   <= 1'b1;
              bus.wb_addr <= rd_q;
              bus.wb_data <= ext;
            end
          end else begin
            cnt <= cnt_nx;
            if (tmo) begin
              state        <= IDLE;
              bus.dmem_req <= 1'b0;
              bus.bus_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage against a transaction-level model,
// plus directed spot checks with hand-computed values.
module tb_mem_access_stage;
  localparam int TO = 16;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage_if bus();

  mem_access_stage #(
    .cDataWidth (32),
    .cRegSelBitW(5),
    .cAckTimeout(TO)
  ) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          lat_cfg   = 0;
  bit          rdata_fix = 1'b1;
  logic [31:0] rdata_val = '0;
  bit          late_ack  = 1'b0;
  bit          noise     = 1'b0;

  bit          m_rst, m_busy, m_req, m_we, m_st, m_ld;
  logic [31:0] m_addr, m_wd;
  logic [3:0]  m_be;
  int          m_sz, m_wait;
  logic [2:0]  m_op;
  logic [1:0]  m_lo;
  logic [4:0]  m_rd;
  bit          e_wbdv, e_berr, e_mis;
  logic [4:0]  e_wba;
  logic [31:0] e_wbd;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int size_of(bit st, logic [2:0] op);
    if (st) return (op == 3'd0) ? 1 : (op == 3'd1) ? 2 : 4;
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [3:0] be_of(int sz, logic [1:0] lo);
    if (sz == 1) return 4'b0001 << lo;
    if (sz == 2) return 4'b0011 << (lo & 2'b10);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] lanes(int sz, logic [31:0] dv);
    if (sz == 1) return {24'd0, dv[7:0]} * 32'h01010101;
    if (sz == 2) return {16'd0, dv[15:0]} * 32'h00010001;
    return dv;
  endfunction

  function automatic logic [31:0] extend(logic [2:0] op,
                                        logic [1:0] lo,
                                        logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * lo)) & 32'hFF;
    h = (rd >> (16 * lo[1])) & 32'hFFFF;
    case (op)
      3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  task automatic model_step();
    bit r, w;
    logic [31:0] a;
    e_wbdv = 1'b0;
    e_berr = 1'b0;
    e_mis  = 1'b0;
    m_rst  = !rstN;
    if (!rstN) begin
      m_busy = 0; m_req = 0; m_we = 0; m_st = 0; m_ld = 0;
      m_addr = '0; m_wd = '0; m_be = '0; m_sz = 0;
      e_wba  = '0; e_wbd = '0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        r = bus.in_memOp.read;
        w = bus.in_memOp.write;
        a = bus.in_memOp.addr;
        if (!(r || w)) begin
          e_wbdv = bus.in_regOp.dv && (bus.in_regOp.addr != 0);
          e_wba  = bus.in_regOp.addr;
          e_wbd  = bus.in_regOp.data;
        end else begin
          m_sz = size_of(w, bus.in_memOp.opType);
          if (TRAP && (int'(a[1:0]) % m_sz != 0)) begin
            e_mis = 1'b1;
          end else begin
            m_busy = 1; m_req = 1; m_we = w; m_st = w;
            m_ld   = !w;
            m_addr = a & ~32'd3;
            m_be   = be_of(m_sz, a[1:0]);
            m_wd   = lanes(m_sz, bus.in_memOp.data);
            m_op   = bus.in_memOp.opType;
            m_lo   = a[1:0];
            m_rd   = bus.in_memOp.rdAddr;
            m_wait = 0;
          end
        end
      end
    end else if (bus.dmem_ack) begin
      m_busy = 0;
      m_req  = 0;
      if (m_ld && m_rd != 0) begin
        e_wbdv = 1'b1;
        e_wba  = m_rd;
        e_wbd  = extend(m_op, m_lo, bus.dmem_rdata);
      end
    end else begin
      m_wait++;
      if (m_wait == TO) begin
        m_busy = 0;
        m_req  = 0;
        e_berr = 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("in_ready", bus.in_ready, !m_busy);
    chk("dmem_req", bus.dmem_req, m_req);
    if (m_req || m_rst) begin
      chk("dmem_we", bus.dmem_we, m_we);
      chk("dmem_addr", bus.dmem_addr, m_addr);
      if (m_st || m_sz == 4 || m_rst)
        chk("dmem_be", bus.dmem_be, m_be);
      if (m_st || m_rst)
        chk("dmem_wdata", bus.dmem_wdata, m_wd);
    end
    chk("wb_dv", bus.wb_dv, e_wbdv);
    if (e_wbdv || m_rst) begin
      chk("wb_addr", bus.wb_addr, e_wba);
      chk("wb_data", bus.wb_data, e_wbd);
    end
    chk("bus_err", bus.bus_err, e_berr);
    chk("misalign_err", bus.misalign_err, e_mis);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      compare();
    end
  end

  initial begin
    int wc;
    int lat;
    wc  = 0;
    lat = 0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.dmem_rdata = rdata_fix ? rdata_val : $urandom();
      if (rstN && bus.dmem_req) begin
        if (wc == 0)
          lat = (lat_cfg >= 0) ? lat_cfg :
                ($urandom_range(0, 7) == 0) ? 40 :
                int'($urandom_range(0, 4));
        bus.dmem_ack = (wc == lat) || late_ack;
        wc++;
      end else begin
        bus.dmem_ack = late_ack ||
                       (noise && $urandom_range(0, 7) == 0);
        wc = 0;
      end
    end
  end

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.in_memOp = '0;
    bus.in_regOp = '0;
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!bus.in_ready && g < 64) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_wait: in_ready got 0 want 1 @%0t", $time);
    end
  endtask

  task automatic set_mem(input bit r, input bit w,
                         input logic [31:0] a,
                         input logic [31:0] dv,
                         input logic [2:0] op,
                         input logic [4:0] rd);
    drive_idle();
    bus.in_valid         = 1'b1;
    bus.in_memOp.read    = r;
    bus.in_memOp.write   = w;
    bus.in_memOp.addr    = a;
    bus.in_memOp.data    = dv;
    bus.in_memOp.opType  = op;
    bus.in_memOp.rdAddr  = rd;
  endtask

  task automatic do_load(input string nm,
                         input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] rd_data,
                         input logic [4:0] rd,
                         input bit exp_dv,
                         input logic [31:0] exp);
    lat_cfg   = 0;
    rdata_fix = 1'b1;
    rdata_val = rd_data;
    @(negedge clk);
    wait_ready();
    set_mem(1'b1, 1'b0, a, 32'h0, op, rd);
    @(posedge clk); #2;
    chk({nm, "_req"}, bus.dmem_req, 1'b1);
    chk({nm, "_we"}, bus.dmem_we, 1'b0);
    @(negedge clk);
    drive_idle();
    @(posedge clk); #2;
    chk({nm, "_wbdv"}, bus.wb_dv, exp_dv);
    if (exp_dv) begin
      chk({nm, "_wbaddr"}, bus.wb_addr, rd);
      chk({nm, "_wbdata"}, bus.wb_data, exp);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_req", bus.dmem_req, 1'b0);
    chk("rst_wbdv", bus.wb_dv, 1'b0);
    chk("rst_wbdata", bus.wb_data, 32'h0);
    chk("rst_berr", bus.bus_err, 1'b0);
    chk("rst_mis", bus.misalign_err, 1'b0);
    @(negedge clk);
    rstN = 1'b1;

    // non-memory writeback, back to back
    @(negedge clk);
    wait_ready();
    bus.in_valid        = 1'b1;
    bus.in_regOp.dv     = 1'b1;
    bus.in_regOp.addr   = 5'd5;
    bus.in_regOp.data   = 32'hDEADBEEF;
    @(posedge clk); #2;
    chk("nm_wbdv", bus.wb_dv, 1'b1);
    chk("nm_wbaddr", bus.wb_addr, 32'd5);
    chk("nm_wbdata", bus.wb_data, 32'hDEADBEEF);
    chk("nm_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_regOp.addr = 5'd0;
    @(posedge clk); #2;
    chk("nm_x0_wbdv", bus.wb_dv, 1'b0);
    chk("nm_x0_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    drive_idle();

    // SB with ack three cycles after the request
    lat_cfg = 2;
    @(negedge clk);
    wait_ready();
    set_mem(1'b0, 1'b1, 32'h1003, 32'hA5, 3'd0, 5'd0);
    @(posedge clk); #2;
    chk("sb_req", bus.dmem_req, 1'b1);
    chk("sb_we", bus.dmem_we, 1'b1);
    chk("sb_addr", bus.dmem_addr, 32'h1000);
    chk("sb_be", bus.dmem_be, 4'b1000);
    chk("sb_wdata", bus.dmem_wdata, 32'hA5A5A5A5);
    chk("sb_busy", bus.in_ready, 1'b0);
    @(negedge clk);
    drive_idle();
    repeat (2) @(posedge clk);
    #2;
    chk("sb_hold_req", bus.dmem_req, 1'b1);
    chk("sb_hold_addr", bus.dmem_addr, 32'h1000);
    @(posedge clk); #2;
    chk("sb_done_req", bus.dmem_req, 1'b0);
    chk("sb_done_ready", bus.in_ready, 1'b1);
    chk("sb_done_wbdv", bus.wb_dv, 1'b0);

    // load extraction
    do_load("lb", 3'd0, 32'h2001, 32'h12348056, 5'd7,
            1'b1, 32'hFFFFFF80);
    do_load("lbu", 3'd4, 32'h2001, 32'h12348056, 5'd7,
            1'b1, 32'h00000080);
    do_load("lh", 3'd1, 32'h2002, 32'hBEEF1234, 5'd7,
            1'b1, 32'hFFFFBEEF);
    do_load("lhu", 3'd5, 32'h2002, 32'hBEEF1234, 5'd7,
            1'b1, 32'h0000BEEF);
    do_load("lw_x0", 3'd2, 32'h2004, 32'h55AA55AA, 5'd0,
            1'b0, 32'h0);

    // timeout
    lat_cfg = 1000;
    @(negedge clk);
    wait_ready();
    set_mem(1'b1, 1'b0, 32'h4000, 32'h0, 3'd2, 5'd3);
    @(posedge clk); #2;
    chk("to_req", bus.dmem_req, 1'b1);
    @(negedge clk);
    drive_idle();
    repeat (15) @(posedge clk);
    #2;
    chk("to_req_15", bus.dmem_req, 1'b1);
    chk("to_berr_15", bus.bus_err, 1'b0);
    @(posedge clk); #2;
    chk("to_berr", bus.bus_err, 1'b1);
    chk("to_req_off", bus.dmem_req, 1'b0);
    chk("to_wbdv", bus.wb_dv, 1'b0);
    chk("to_ready", bus.in_ready, 1'b1);
    @(posedge clk); #2;
    chk("to_berr_pulse", bus.bus_err, 1'b0);

    // asynchronous reset mid-access, then a stale ack
    @(negedge clk);
    wait_ready();
    set_mem(1'b1, 1'b0, 32'h5000, 32'h0, 3'd2, 5'd9);
    @(posedge clk); #2;
    chk("rs_req", bus.dmem_req, 1'b1);
    @(negedge clk);
    drive_idle();
    @(posedge clk); #3;
    rstN = 1'b0;
    #1;
    chk("rs_req_drop", bus.dmem_req, 1'b0);
    chk("rs_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rstN     = 1'b1;
    late_ack = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    chk("rs_late_wbdv", bus.wb_dv, 1'b0);
    chk("rs_late_req", bus.dmem_req, 1'b0);
    chk("rs_late_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    late_ack = 1'b0;

    // misaligned word
    lat_cfg = 0;
    @(negedge clk);
    wait_ready();
    set_mem(1'b1, 1'b0, 32'h3002, 32'h0, 3'd2, 5'd4);
    @(posedge clk); #2;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_err", bus.misalign_err, 1'b1);
    chk("mis_req", bus.dmem_req, 1'b0);
    chk("mis_ready", bus.in_ready, 1'b1);
`else
    chk("mis_req", bus.dmem_req, 1'b1);
    chk("mis_addr", bus.dmem_addr, 32'h3000);
    chk("mis_be", bus.dmem_be, 4'b1111);
    chk("mis_err", bus.misalign_err, 1'b0);
`endif
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);

    // randomised traffic
    lat_cfg   = -1;
    rdata_fix = 1'b0;
    noise     = 1'b1;
    repeat (4000) begin
      int k;
      @(negedge clk);
      drive_idle();
      bus.in_valid = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 3);
      bus.in_memOp.read   = (k == 1) || (k == 3);
      bus.in_memOp.write  = (k == 2) || (k == 3);
      bus.in_memOp.addr   = $urandom();
      bus.in_memOp.data   = $urandom();
      bus.in_memOp.opType = 3'($urandom_range(0, 7));
      bus.in_memOp.rdAddr = ($urandom_range(0, 5) == 0) ? 5'd0
                          : 5'($urandom_range(1, 31));
      bus.in_regOp.dv     = 1'($urandom_range(0, 1));
      bus.in_regOp.addr   = ($urandom_range(0, 5) == 0) ? 5'd0
                          : 5'($urandom_range(1, 31));
      bus.in_regOp.data   = $urandom();
    end
    @(negedge clk);
    drive_idle();
    noise = 1'b0;
    wait_ready();
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
